// File: rtl/pci_dma_pkg.sv
// Shared widths, FSM encodings and AXI constants for the PCI DMA arbiter.
package pci_dma_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ADDR = 1'b1
  } rstate_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Captured address-channel payload, held stable while VALID is up downstream.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        cache;
  } ax_t;

endpackage

// File: rtl/pci_rr_arbiter.sv
// Round-robin picker: first requester after the last granted one wins.
module pci_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_adv,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [PORT_BITS-1:0] o_idx,
  output logic                 o_any
);

  logic [PORT_BITS-1:0] r_ptr;

  // Scan cyclically starting just after the pointer; the pointer itself is checked last.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!o_any && i_req[PORT_BITS'((int'(r_ptr) + i) % NUM_PORTS)]) begin
        o_any = 1'b1;
        o_idx = PORT_BITS'((int'(r_ptr) + i) % NUM_PORTS);
      end
    end
    o_gnt = o_any ? (NUM_PORTS'(1) << o_idx) : '0;
  end

  // Pointer parks on the last winner; reset value makes port 0 win first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        r_ptr <= PORT_BITS'(NUM_PORTS - 1);
    else if (i_adv) r_ptr <= o_idx;
  end

endmodule

// File: rtl/pci_dma_arbiter.sv
// Shares one AXI3 DMA master port between NUM_PORTS DMA engines.
// AW and AR are arbitrated independently per burst; the port index rides in
// the downstream ID MSBs and steers B/R back to the requester.
module pci_dma_arbiter
  import pci_dma_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_BITS = 1,
  parameter int SID_BITS  = 3,
  parameter int MAX_OUT   = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  // write address, per port
  input  logic [NUM_PORTS-1:0][SID_BITS-1:0]    s_awid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      s_awaddr,
  input  logic [NUM_PORTS-1:0][7:0]             s_awlen,
  input  logic [NUM_PORTS-1:0][2:0]             s_awsize,
  input  logic [NUM_PORTS-1:0][1:0]             s_awburst,
  input  logic [NUM_PORTS-1:0][3:0]             s_awcache,
  input  logic [NUM_PORTS-1:0]                  s_awvalid,
  output logic [NUM_PORTS-1:0]                  s_awready,
  // write data, per port
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]      s_wdata,
  input  logic [NUM_PORTS-1:0][STRB_W-1:0]      s_wstrb,
  input  logic [NUM_PORTS-1:0]                  s_wlast,
  input  logic [NUM_PORTS-1:0]                  s_wvalid,
  output logic [NUM_PORTS-1:0]                  s_wready,
  // write response, per port
  output logic [NUM_PORTS-1:0][SID_BITS-1:0]    s_bid,
  output logic [NUM_PORTS-1:0][1:0]             s_bresp,
  output logic [NUM_PORTS-1:0]                  s_bvalid,
  input  logic [NUM_PORTS-1:0]                  s_bready,
  // read address, per port
  input  logic [NUM_PORTS-1:0][SID_BITS-1:0]    s_arid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      s_araddr,
  input  logic [NUM_PORTS-1:0][7:0]             s_arlen,
  input  logic [NUM_PORTS-1:0][2:0]             s_arsize,
  input  logic [NUM_PORTS-1:0][1:0]             s_arburst,
  input  logic [NUM_PORTS-1:0][3:0]             s_arcache,
  input  logic [NUM_PORTS-1:0]                  s_arvalid,
  output logic [NUM_PORTS-1:0]                  s_arready,
  // read data, per port
  output logic [NUM_PORTS-1:0][SID_BITS-1:0]    s_rid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]      s_rdata,
  output logic [NUM_PORTS-1:0][1:0]             s_rresp,
  output logic [NUM_PORTS-1:0]                  s_rlast,
  output logic [NUM_PORTS-1:0]                  s_rvalid,
  input  logic [NUM_PORTS-1:0]                  s_rready,
  // downstream master port
  output logic [ID_W-1:0]                       m_awid,
  output logic [ADDR_W-1:0]                     m_awaddr,
  output logic [7:0]                            m_awlen,
  output logic [2:0]                            m_awsize,
  output logic [1:0]                            m_awburst,
  output logic [3:0]                            m_awcache,
  output logic                                  m_awvalid,
  input  logic                                  m_awready,
  output logic [ID_W-1:0]                       m_wid,
  output logic [DATA_W-1:0]                     m_wdata,
  output logic [STRB_W-1:0]                     m_wstrb,
  output logic                                  m_wlast,
  output logic                                  m_wvalid,
  input  logic                                  m_wready,
  input  logic [ID_W-1:0]                       m_bid,
  input  logic [1:0]                            m_bresp,
  input  logic                                  m_bvalid,
  output logic                                  m_bready,
  output logic [ID_W-1:0]                       m_arid,
  output logic [ADDR_W-1:0]                     m_araddr,
  output logic [7:0]                            m_arlen,
  output logic [2:0]                            m_arsize,
  output logic [1:0]                            m_arburst,
  output logic [3:0]                            m_arcache,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [ID_W-1:0]                       m_rid,
  input  logic [DATA_W-1:0]                     m_rdata,
  input  logic [1:0]                            m_rresp,
  input  logic                                  m_rlast,
  input  logic                                  m_rvalid,
  output logic                                  m_rready
);

  wstate_e              r_wstate, w_wstate_nxt;
  rstate_e              r_rstate, w_rstate_nxt;
  ax_t                  r_aw, r_ar;
  logic [PORT_BITS-1:0] r_wg;
  logic [CNT_W-1:0]     r_wr_cnt, r_rd_cnt;

  logic [NUM_PORTS-1:0] w_awgnt, w_argnt;
  logic [PORT_BITS-1:0] w_awidx, w_aridx, w_bidx, w_ridx;
  logic                 w_awany, w_arany, w_aw_acc, w_ar_acc;
  logic                 w_aw_hs, w_ar_hs, w_b_hs, w_rl_hs, w_wbeat;

  pci_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_aw_arb (
    .CLK(CLK), .RST(RST), .i_req(s_awvalid), .i_adv(w_aw_acc),
    .o_gnt(w_awgnt), .o_idx(w_awidx), .o_any(w_awany)
  );

  pci_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_ar_arb (
    .CLK(CLK), .RST(RST), .i_req(s_arvalid), .i_adv(w_ar_acc),
    .o_gnt(w_argnt), .o_idx(w_aridx), .o_any(w_arany)
  );

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_b_hs  = m_bvalid & m_bready;
  assign w_rl_hs = m_rvalid & m_rready & m_rlast;

  assign m_awvalid = (r_wstate == W_ADDR);
  assign m_awid    = r_aw.id;
  assign m_awaddr  = r_aw.addr;
  assign m_awlen   = r_aw.len;
  assign m_awsize  = r_aw.size;
  assign m_awburst = r_aw.burst;
  assign m_awcache = r_aw.cache;
  assign m_wid     = r_aw.id;

  assign m_arvalid = (r_rstate == R_ADDR);
  assign m_arid    = r_ar.id;
  assign m_araddr  = r_ar.addr;
  assign m_arlen   = r_ar.len;
  assign m_arsize  = r_ar.size;
  assign m_arburst = r_ar.burst;
  assign m_arcache = r_ar.cache;

  // Write FSM: one burst at a time end-to-end keeps W order identical to AW order.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_acc     = 1'b0;
    s_awready    = '0;
    s_wready     = '0;
    m_wvalid     = 1'b0;
    m_wdata      = '0;
    m_wstrb      = '0;
    m_wlast      = 1'b0;
    w_wbeat      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (!RST && w_awany && r_wr_cnt < CNT_W'(MAX_OUT)) begin
          w_aw_acc     = 1'b1;
          s_awready    = w_awgnt;
          w_wstate_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        if (m_awready) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        m_wvalid       = s_wvalid[r_wg];
        m_wdata        = s_wdata[r_wg];
        m_wstrb        = s_wstrb[r_wg];
        m_wlast        = s_wlast[r_wg];
        s_wready[r_wg] = m_wready;
        w_wbeat        = s_wvalid[r_wg] & m_wready & s_wlast[r_wg];
        if (w_wbeat) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM: address only, data returns independently through R routing.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_acc     = 1'b0;
    s_arready    = '0;
    case (r_rstate)
      R_IDLE: begin
        if (!RST && w_arany && r_rd_cnt < CNT_W'(MAX_OUT)) begin
          w_ar_acc     = 1'b1;
          s_arready    = w_argnt;
          w_rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_arready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Capture the granted request with its port index prepended to the ID.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_aw <= '0;
      r_ar <= '0;
      r_wg <= '0;
    end else begin
      if (w_aw_acc) begin
        r_aw.id    <= {w_awidx, s_awid[w_awidx]};
        r_aw.addr  <= s_awaddr[w_awidx];
        r_aw.len   <= s_awlen[w_awidx];
        r_aw.size  <= s_awsize[w_awidx];
        r_aw.burst <= s_awburst[w_awidx];
        r_aw.cache <= s_awcache[w_awidx];
        r_wg       <= w_awidx;
      end
      if (w_ar_acc) begin
        r_ar.id    <= {w_aridx, s_arid[w_aridx]};
        r_ar.addr  <= s_araddr[w_aridx];
        r_ar.len   <= s_arlen[w_aridx];
        r_ar.size  <= s_arsize[w_aridx];
        r_ar.burst <= s_arburst[w_aridx];
        r_ar.cache <= s_arcache[w_aridx];
      end
    end
  end

  // Outstanding-burst counters; simultaneous issue and completion cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_aw_hs && !w_b_hs)                         r_wr_cnt <= r_wr_cnt + 1'b1;
      else if (!w_aw_hs && w_b_hs && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - 1'b1;
      if (w_ar_hs && !w_rl_hs)                         r_rd_cnt <= r_rd_cnt + 1'b1;
      else if (!w_ar_hs && w_rl_hs && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - 1'b1;
    end
  end

  assign w_bidx = m_bid[ID_W-1 -: PORT_BITS];
  assign w_ridx = m_rid[ID_W-1 -: PORT_BITS];

  // B/R routing: payload broadcast, only VALID/READY steered by the ID MSBs.
  always_comb begin
    s_bvalid = '0;
    s_rvalid = '0;
    m_bready = 1'b0;
    m_rready = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      s_bid[p]   = m_bid[SID_BITS-1:0];
      s_bresp[p] = m_bresp;
      s_rid[p]   = m_rid[SID_BITS-1:0];
      s_rdata[p] = m_rdata;
      s_rresp[p] = m_rresp;
      s_rlast[p] = m_rlast;
    end
    if (!RST) begin
      s_bvalid[w_bidx] = m_bvalid;
      m_bready         = s_bready[w_bidx];
      s_rvalid[w_ridx] = m_rvalid;
      m_rready         = s_rready[w_ridx];
    end
  end

  // A response with nothing outstanding is a bridge protocol error.
  a_no_b_underflow: assert property (@(posedge CLK) disable iff (RST) !(w_b_hs && r_wr_cnt == '0));
  a_no_r_underflow: assert property (@(posedge CLK) disable iff (RST) !(w_rl_hs && r_rd_cnt == '0));

endmodule

// File: tb/tb_pci_dma_arbiter.sv
// Directed bench for pci_dma_arbiter (2 ports).
module tb_pci_dma_arbiter;

  localparam int NP = 2;
  localparam int SB = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [NP-1:0][SB-1:0] s_awid, s_arid, s_bid, s_rid;
  logic [NP-1:0][63:0]   s_awaddr, s_araddr;
  logic [NP-1:0][7:0]    s_awlen, s_arlen;
  logic [NP-1:0][2:0]    s_awsize, s_arsize;
  logic [NP-1:0][1:0]    s_awburst, s_arburst, s_bresp, s_rresp;
  logic [NP-1:0][3:0]    s_awcache, s_arcache, s_wstrb;
  logic [NP-1:0][31:0]   s_wdata, s_rdata;
  logic [NP-1:0]         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [NP-1:0]         s_bvalid, s_bready, s_arvalid, s_arready;
  logic [NP-1:0]         s_rlast, s_rvalid, s_rready;
  logic [3:0]  m_awid, m_wid, m_bid, m_arid, m_rid, m_awcache, m_arcache, m_wstrb;
  logic [63:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [31:0] m_wdata, m_rdata;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  int n_tests = 0;
  int n_fail  = 0;

  pci_dma_arbiter #(.NUM_PORTS(2), .PORT_BITS(1), .SID_BITS(3), .MAX_OUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awcache(s_awcache), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic clr_inputs();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awcache = '0;
    s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arcache = '0;
    s_arvalid = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  // Drives n beats from port p at successive negedges; leaves caller at a negedge.
  task automatic wburst(input int p, input logic [31:0] base, input int n, input logic [3:0] id);
    logic [NP-1:0] e;
    e = '0; e[p] = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_wvalid[p] = 1'b1; s_wdata[p] = base + 32'(k); s_wstrb[p] = 4'hF;
      s_wlast[p] = (k == n - 1); m_wready = 1'b1;
      #1;
      n_tests++;
      if (m_wvalid !== 1'b1 || m_wdata !== base + 32'(k) || m_wlast !== (k == n - 1) || m_wid !== id) begin
        n_fail++;
        $display("FAIL w_beat p%0d k%0d: got v=%b d=%h l=%b id=%b want v=1 d=%h l=%b id=%b",
                 p, k, m_wvalid, m_wdata, m_wlast, m_wid, base + 32'(k), (k == n - 1), id);
      end
      n_tests++;
      if (s_wready !== e) begin
        n_fail++; $display("FAIL w_ready p%0d k%0d: got %b want %b", p, k, s_wready, e);
      end
      @(negedge CLK);
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; m_wready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    s_awvalid = 2'b11; s_arvalid = 2'b11; m_bvalid = 1'b1; s_bready = 2'b11;
    m_rvalid = 1'b1; s_rready = 2'b11;
    #1;
    n_tests++;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready} !== '0) begin
      n_fail++;
      $display("FAIL reset_hs: got awr=%b arr=%b wr=%b bv=%b rv=%b maw=%b mar=%b mw=%b mb=%b mr=%b want all 0",
               s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready);
    end
    n_tests++;
    if ({m_awid, m_awaddr, m_arid, m_araddr} !== '0) begin
      n_fail++; $display("FAIL reset_payload: got awid=%h awaddr=%h arid=%h araddr=%h want 0",
                         m_awid, m_awaddr, m_arid, m_araddr);
    end
    clr_inputs();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_rr_write();
    @(negedge CLK);
    s_awvalid = 2'b11;
    s_awid[0] = 3'b101; s_awaddr[0] = 64'h1000; s_awlen[0] = 8'd3;
    s_awid[1] = 3'b011; s_awaddr[1] = 64'h2000; s_awlen[1] = 8'd3;
    s_awsize = {3'd2, 3'd2}; s_awburst = {2'd1, 2'd1}; s_awcache = {4'h3, 4'h3};
    #1;
    n_tests++;
    if (s_awready !== 2'b01) begin n_fail++; $display("FAIL rr_first_gnt: got %b want 01", s_awready); end
    @(negedge CLK);
    s_awvalid = 2'b10; m_awready = 1'b1;
    #1;
    n_tests++;
    if (m_awvalid !== 1'b1 || m_awid !== 4'b0101 || m_awaddr !== 64'h1000 || m_awlen !== 8'd3) begin
      n_fail++; $display("FAIL aw0_out: got v=%b id=%b addr=%h len=%0d want v=1 id=0101 addr=1000 len=3",
                         m_awvalid, m_awid, m_awaddr, m_awlen);
    end
    n_tests++;
    if (s_awready !== 2'b00) begin n_fail++; $display("FAIL aw_busy: got %b want 00", s_awready); end
    @(negedge CLK);
    m_awready = 1'b0;
    wburst(0, 32'hA000_0000, 4, 4'b0101);
    #1;
    n_tests++;
    if (s_awready !== 2'b10) begin n_fail++; $display("FAIL rr_second_gnt: got %b want 10", s_awready); end
    @(negedge CLK);
    s_awvalid = 2'b00; m_awready = 1'b1;
    #1;
    n_tests++;
    if (m_awvalid !== 1'b1 || m_awid !== 4'b1011 || m_awaddr !== 64'h2000) begin
      n_fail++; $display("FAIL aw1_out: got v=%b id=%b addr=%h want v=1 id=1011 addr=2000",
                         m_awvalid, m_awid, m_awaddr);
    end
    @(negedge CLK);
    m_awready = 1'b0;
    wburst(1, 32'hB000_0000, 4, 4'b1011);
  endtask

  task automatic test_b_route();
    m_bvalid = 1'b1; m_bid = 4'b1010; m_bresp = 2'b10; s_bready = 2'b00;
    #1;
    n_tests++;
    if (s_bvalid !== 2'b10 || s_bid[1] !== 3'b010 || s_bresp[1] !== 2'b10) begin
      n_fail++; $display("FAIL b_route1: got bv=%b bid=%b resp=%b want bv=10 bid=010 resp=10",
                         s_bvalid, s_bid[1], s_bresp[1]);
    end
    n_tests++;
    if (m_bready !== 1'b0) begin n_fail++; $display("FAIL b_hold: got %b want 0", m_bready); end
    @(negedge CLK);
    #1;
    n_tests++;
    if (m_bready !== 1'b0) begin n_fail++; $display("FAIL b_hold2: got %b want 0", m_bready); end
    s_bready = 2'b10;
    #1;
    n_tests++;
    if (m_bready !== 1'b1) begin n_fail++; $display("FAIL b_ready1: got %b want 1", m_bready); end
    @(negedge CLK);
    m_bid = 4'b0101; m_bresp = 2'b00; s_bready = 2'b01;
    #1;
    n_tests++;
    if (s_bvalid !== 2'b01 || s_bid[0] !== 3'b101 || m_bready !== 1'b1) begin
      n_fail++; $display("FAIL b_route0: got bv=%b bid=%b mb=%b want bv=01 bid=101 mb=1",
                         s_bvalid, s_bid[0], m_bready);
    end
    @(negedge CLK);
    m_bvalid = 1'b0; s_bready = 2'b00;
  endtask

  task automatic test_ar_limit();
    for (int i = 0; i < 8; i++) begin
      s_arvalid = 2'b01; s_arid[0] = 3'(i); s_araddr[0] = 64'h4000 + 64'(i * 64);
      #1;
      n_tests++;
      if (s_arready !== 2'b01) begin n_fail++; $display("FAIL ar_acc%0d: got %b want 01", i, s_arready); end
      @(negedge CLK);
      s_arvalid = 2'b00; m_arready = 1'b1;
      #1;
      n_tests++;
      if (m_arvalid !== 1'b1 || m_arid !== {1'b0, 3'(i)}) begin
        n_fail++; $display("FAIL ar_out%0d: got v=%b id=%b want v=1 id=%b", i, m_arvalid, m_arid, {1'b0, 3'(i)});
      end
      @(negedge CLK);
      m_arready = 1'b0;
    end
    s_arvalid = 2'b01; s_arid[0] = 3'd7; s_araddr[0] = 64'h9000;
    #1;
    n_tests++;
    if (s_arready !== 2'b00) begin n_fail++; $display("FAIL ar_stall: got %b want 00", s_arready); end
    @(negedge CLK);
    m_rvalid = 1'b1; m_rid = 4'b0000; m_rlast = 1'b1; m_rdata = 32'h1234_5678; s_rready = 2'b01;
    #1;
    n_tests++;
    if (s_arready !== 2'b00 || s_rvalid !== 2'b01) begin
      n_fail++; $display("FAIL ar_stall2: got arr=%b rv=%b want arr=00 rv=01", s_arready, s_rvalid);
    end
    @(negedge CLK);
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    #1;
    n_tests++;
    if (s_arready !== 2'b01) begin n_fail++; $display("FAIL ar_resume: got %b want 01", s_arready); end
    @(negedge CLK);
    s_arvalid = 2'b00; m_arready = 1'b1;
    #1;
    n_tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 64'h9000) begin
      n_fail++; $display("FAIL ar9_out: got v=%b addr=%h want v=1 addr=9000", m_arvalid, m_araddr);
    end
    @(negedge CLK);
    m_arready = 1'b0;
  endtask

  task automatic test_r_interleave();
    logic [3:0]  rids  [4] = '{4'b0001, 4'b1001, 4'b0001, 4'b1001};
    logic [31:0] rdats [4] = '{32'hD0D0_0000, 32'hD1D1_0001, 32'hD0D0_0002, 32'hD1D1_0003};
    logic        rlsts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    s_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int ix;
      logic [NP-1:0] e;
      ix = (k % 2 == 1) ? 1 : 0;
      e = '0; e[ix] = 1'b1;
      m_rvalid = 1'b1; m_rid = rids[k]; m_rdata = rdats[k]; m_rlast = rlsts[k];
      #1;
      n_tests++;
      if (s_rvalid !== e || s_rid[ix] !== 3'b001 || s_rdata[ix] !== rdats[k] ||
          s_rlast[ix] !== rlsts[k] || m_rready !== 1'b1) begin
        n_fail++; $display("FAIL r_route%0d: got rv=%b id=%b d=%h l=%b mr=%b want rv=%b id=001 d=%h l=%b mr=1",
                           k, s_rvalid, s_rid[ix], s_rdata[ix], s_rlast[ix], m_rready, e, rdats[k], rlsts[k]);
      end
      @(negedge CLK);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
  endtask

  task automatic test_w_stall();
    s_awvalid = 2'b01; s_awid[0] = 3'b110; s_awaddr[0] = 64'h5000; s_awlen[0] = 8'd3;
    s_wvalid[1] = 1'b1; s_wdata[1] = 32'hCAFE_0001; s_wstrb[1] = 4'hF; s_wlast[1] = 1'b1;
    m_wready = 1'b1;
    #1;
    n_tests++;
    if (s_awready !== 2'b01 || s_wready !== 2'b00) begin
      n_fail++; $display("FAIL stall_idle: got awr=%b wr=%b want awr=01 wr=00", s_awready, s_wready);
    end
    @(negedge CLK);
    s_awvalid = 2'b10; s_awid[1] = 3'b001; s_awaddr[1] = 64'h6000; s_awlen[1] = 8'd0;
    m_awready = 1'b1;
    #1;
    n_tests++;
    if (s_wready !== 2'b00 || m_wvalid !== 1'b0) begin
      n_fail++; $display("FAIL stall_addr: got wr=%b mw=%b want wr=00 mw=0", s_wready, m_wvalid);
    end
    @(negedge CLK);
    m_awready = 1'b0;
    wburst(0, 32'hC000_0000, 4, 4'b0110);
    s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1;
    #1;
    n_tests++;
    if (s_awready !== 2'b10 || s_wready !== 2'b00) begin
      n_fail++; $display("FAIL stall_regrant: got awr=%b wr=%b want awr=10 wr=00", s_awready, s_wready);
    end
    @(negedge CLK);
    s_awvalid = 2'b00; m_awready = 1'b1;
    #1;
    n_tests++;
    if (m_awid !== 4'b1001 || s_wready !== 2'b00) begin
      n_fail++; $display("FAIL stall_aw1: got id=%b wr=%b want id=1001 wr=00", m_awid, s_wready);
    end
    @(negedge CLK);
    m_awready = 1'b0; m_wready = 1'b1;
    #1;
    n_tests++;
    if (s_wready !== 2'b10 || m_wdata !== 32'hCAFE_0001 || m_wlast !== 1'b1) begin
      n_fail++; $display("FAIL zero_len_beat: got wr=%b d=%h l=%b want wr=10 d=cafe0001 l=1",
                         s_wready, m_wdata, m_wlast);
    end
    @(negedge CLK);
    #1;
    n_tests++;
    if (m_wvalid !== 1'b0 || s_wready !== 2'b00) begin
      n_fail++; $display("FAIL zero_len_end: got mw=%b wr=%b want mw=0 wr=00", m_wvalid, s_wready);
    end
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    s_awvalid = 2'b11;
    s_awid[0] = 3'b010; s_awaddr[0] = 64'h7000; s_awlen[0] = 8'd3;
    s_awid[1] = 3'b111; s_awaddr[1] = 64'h8000; s_awlen[1] = 8'd3;
    #1;
    n_tests++;
    if (s_awready !== 2'b01) begin n_fail++; $display("FAIL mid_gnt: got %b want 01", s_awready); end
    @(negedge CLK);
    s_awvalid = 2'b10; m_awready = 1'b1;
    @(negedge CLK);
    m_awready = 1'b0;
    s_wvalid[0] = 1'b1; s_wdata[0] = 32'hE000_0000; m_wready = 1'b1;
    #1;
    n_tests++;
    if (s_wready !== 2'b01) begin n_fail++; $display("FAIL mid_beat1: got %b want 01", s_wready); end
    @(negedge CLK);
    s_wdata[0] = 32'hE000_0001;
    RST = 1'b1; m_bvalid = 1'b1; m_bid = 4'b0000; s_bready = 2'b11;
    m_rvalid = 1'b1; m_rid = 4'b0000; s_rready = 2'b11; s_arvalid = 2'b01;
    #1;
    n_tests++;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_hs: got awr=%b arr=%b wr=%b bv=%b rv=%b maw=%b mar=%b mw=%b mb=%b mr=%b want all 0",
               s_awready, s_arready, s_wready, s_bvalid, s_rvalid, m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready);
    end
    n_tests++;
    if (dut.r_wr_cnt !== 4'd0 || dut.r_rd_cnt !== 4'd0) begin
      n_fail++; $display("FAIL mid_rst_cnt: got wr=%0d rd=%0d want 0 0", dut.r_wr_cnt, dut.r_rd_cnt);
    end
    @(negedge CLK);
    clr_inputs();
    s_awvalid = 2'b11;
    s_awid[0] = 3'b010; s_awaddr[0] = 64'h7000;
    s_awid[1] = 3'b111; s_awaddr[1] = 64'h8000;
    RST = 1'b0;
    #1;
    n_tests++;
    if (s_awready !== 2'b01) begin n_fail++; $display("FAIL post_rst_gnt: got %b want 01", s_awready); end
    @(negedge CLK);
    s_awvalid = 2'b00; m_awready = 1'b1;
    #1;
    n_tests++;
    if (m_awvalid !== 1'b1 || m_awid !== 4'b0010) begin
      n_fail++; $display("FAIL post_rst_aw: got v=%b id=%b want v=1 id=0010", m_awvalid, m_awid);
    end
    @(negedge CLK);
    m_awready = 1'b0;
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_rr_write();
    test_b_route();
    test_ar_limit();
    test_r_interleave();
    test_w_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
